// File: rtl/spi_tx_pkg.sv
// Shared types and helpers for the SPI transmit serializer.
package spi_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    // Bits needed to hold a count of 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial SPI transmitter with valid/ready load, bit-order select and inter-word gap.
// Build option: define SPI_TX_PARITY_EN to append an even-parity bit to every frame.
module spi_tx_serializer
    import spi_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              spi_sck,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              Filter_Output,
    output logic              frame_active,
    output logic              frame_sync,
    output logic              underrun
);

    localparam int unsigned CNT_W = cnt_w(DATA_W);
`ifdef SPI_TX_PARITY_EN
    localparam int unsigned LAST_IDX = DATA_W;
`else
    localparam int unsigned LAST_IDX = DATA_W - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LAST_IDX);
    // The IDLE cycle that accepts the next word is the final gap cycle, so GAP holds GAP_CYCLES-1.
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    localparam bit STREAMING = (GAP_CYCLES == 0);
    localparam bit USE_GAP   = (GAP_CYCLES > 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_reg, shift_d;
    logic [CNT_W-1:0]  bit_cnt, cnt_d;
    logic [7:0]        gap_cnt, gap_d;
    logic              accept;
    logic              out_bit;
    logic              fo_d, fa_d, fs_d, rdy_d, ur_d;
`ifdef SPI_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        shift_d = shift_reg;
        cnt_d   = bit_cnt;
        gap_d   = gap_cnt;
        ur_d    = 1'b0;
`ifdef SPI_TX_PARITY_EN
        parity_d = parity_q;
`endif
        accept  = tx_valid && tx_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = tx_data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (accept) begin
                        shift_d = tx_data;
                        cnt_d   = '0;
                    end else if (USE_GAP) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = IDLE;
                        ur_d    = STREAMING;
                    end
                end else begin
                    shift_d = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                    cnt_d   = bit_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SPI_TX_PARITY_EN
        if (accept) begin
            parity_d = ^tx_data;
        end
`endif

        out_bit = MSB_FIRST ? shift_d[DATA_W-1] : shift_d[0];
`ifdef SPI_TX_PARITY_EN
        if (cnt_d == CNT_W'(DATA_W)) begin
            out_bit = parity_d;
        end
`endif
        fo_d  = (state_d == SHIFT) ? out_bit : IDLE_LEVEL;
        fa_d  = (state_d == SHIFT);
        fs_d  = (state_d == SHIFT) && (cnt_d == '0);
        rdy_d = (state_d == IDLE) ||
                ((state_d == SHIFT) && (cnt_d == LAST_BIT) && STREAMING);
    end

    always_ff @(posedge spi_sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            Filter_Output <= IDLE_LEVEL;
            tx_ready      <= 1'b1;
            frame_active  <= 1'b0;
            frame_sync    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_reg     <= shift_d;
            bit_cnt       <= cnt_d;
            gap_cnt       <= gap_d;
            Filter_Output <= fo_d;
            tx_ready      <= rdy_d;
            frame_active  <= fa_d;
            frame_sync    <= fs_d;
            underrun      <= ur_d;
        end
    end

`ifdef SPI_TX_PARITY_EN
    always_ff @(posedge spi_sck or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Self-checking bench: two serializer instances (MSB-first streaming, LSB-first with gap 3)
// compared every cycle against a frame-timeline model, plus literal frame checks.
module tb_spi_tx_serializer;

    localparam int unsigned DW = 16;
`ifdef SPI_TX_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          spi_sck;
    logic          rst_n;
    logic [DW-1:0] tx_data  [2];
    logic          tx_valid [2];
    logic          tx_ready [2];
    logic          fo       [2];
    logic          fa       [2];
    logic          fs       [2];
    logic          ur       [2];

    int vectors;
    int miscompares;

    // Model: position within the current frame (-1 = none), idle cycles left before ready.
    int            m_pos  [2];
    int            m_gap  [2];
    logic [DW-1:0] m_word [2];
    logic          m_ur   [2];

    spi_tx_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) dut0 (
        .spi_sck(spi_sck), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .Filter_Output(fo[0]), .frame_active(fa[0]),
        .frame_sync(fs[0]), .underrun(ur[0]));

    spi_tx_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) dut1 (
        .spi_sck(spi_sck), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .Filter_Output(fo[1]), .frame_active(fa[1]),
        .frame_sync(fs[1]), .underrun(ur[1]));

    initial spi_sck = 1'b0;
    always #5 spi_sck = ~spi_sck;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic exp_line(input int i);
        if (m_pos[i] < 0) return 1'b1;
        if (m_pos[i] == DW) return ^m_word[i];
        if (i == 0) return m_word[i][DW-1-m_pos[i]];
        return m_word[i][m_pos[i]];
    endfunction

    function automatic logic exp_ready(input int i);
        if (m_pos[i] < 0) return (m_gap[i] == 0);
        return (m_pos[i] == FL - 1) && (gap_of(i) == 0);
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Advance the frame timeline at each clock edge.
    always @(posedge spi_sck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = -1; m_gap[i] = 0; m_ur[i] = 1'b0; m_word[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic acc;
                acc = tx_valid[i] && exp_ready(i);
                m_ur[i] = 1'b0;
                if (m_pos[i] >= 0 && m_pos[i] < FL - 1) begin
                    m_pos[i]++;
                end else if (acc) begin
                    m_pos[i]  = 0;
                    m_word[i] = tx_data[i];
                end else if (m_pos[i] == FL - 1) begin
                    m_pos[i] = -1;
                    m_gap[i] = (gap_of(i) > 0) ? gap_of(i) - 1 : 0;
                    m_ur[i]  = (gap_of(i) == 0);
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge spi_sck) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("line",   i, 32'(fo[i]),       32'(exp_line(i)));
                chk("active", i, 32'(fa[i]),       32'(m_pos[i] >= 0));
                chk("sync",   i, 32'(fs[i]),       32'(m_pos[i] == 0));
                chk("ready",  i, 32'(tx_ready[i]), 32'(exp_ready(i)));
                chk("under",  i, 32'(ur[i]),       32'(m_ur[i]));
            end
        end
    end

    // Present a word, hold it until accepted; called and returns just after a rising edge.
    task automatic send_word(input int i, input logic [DW-1:0] d, input bit keep_valid);
        int n;
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        n = 0;
        @(negedge spi_sck);
        while (!tx_ready[i] && n < 200) begin
            @(negedge spi_sck);
            n++;
        end
        if (!tx_ready[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout inst%0d: tx_ready stayed 0, expected 1", i);
        end
        @(posedge spi_sck);
        #1;
        if (!keep_valid) tx_valid[i] = 1'b0;
    endtask

    // Collect nb line bits, first bit ending up most significant.
    task automatic capture(input int i, input int nb, output logic [31:0] w, output int syncs, output int act);
        w = '0; syncs = 0; act = 0;
        for (int b = 0; b < nb; b++) begin
            @(negedge spi_sck);
            w = {w[30:0], fo[i]};
            syncs += int'(fs[i]);
            act   += int'(fa[i]);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge spi_sck);
        #1;
    endtask

    logic [31:0] w;
    logic [31:0] exp_w;
    int syncs, act, idle;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tx_valid[i] = 1'b0; tx_data[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_line",  i, 32'(fo[i]), 32'd1);
            chk("rst_ready", i, 32'(tx_ready[i]), 32'd1);
            chk("rst_act",   i, 32'(fa[i]), 32'd0);
            chk("rst_under", i, 32'(ur[i]), 32'd0);
        end
        @(posedge spi_sck); #1;
        rst_n = 1'b1;
        settle(2);

        // Single MSB-first word, valid dropped after accept.
        send_word(0, 16'hA5C3, 1'b0);
        capture(0, FL, w, syncs, act);
`ifdef SPI_TX_PARITY_EN
        exp_w = 32'h0001_4B86;
`else
        exp_w = 32'h0000_A5C3;
`endif
        chk("a5c3_bits", 0, w, exp_w);
        chk("a5c3_sync", 0, 32'(syncs), 32'd1);
        chk("a5c3_act",  0, 32'(act), 32'(FL));
        @(negedge spi_sck);
        chk("a5c3_underrun", 0, 32'(ur[0]), 32'd1);
        @(negedge spi_sck);
        chk("a5c3_underrun_end", 0, 32'(ur[0]), 32'd0);
        chk("a5c3_line_idle", 0, 32'(fo[0]), 32'd1);
        settle(2);

        // Back-to-back streaming.
        send_word(0, 16'h0001, 1'b1);
        send_word(0, 16'h8000, 1'b0);
        settle(FL + 4);

        // LSB-first with a 3-cycle gap, valid held across two frames.
        send_word(1, 16'h0003, 1'b1);
        capture(1, FL, w, syncs, act);
`ifdef SPI_TX_PARITY_EN
        exp_w = 32'h0001_8000;
`else
        exp_w = 32'h0000_C000;
`endif
        chk("lsb_bits", 1, w, exp_w);
        idle = 0;
        @(negedge spi_sck);
        while (!fa[1] && idle < 20) begin
            idle++;
            @(negedge spi_sck);
        end
        chk("gap_idle_cycles", 1, 32'(idle), 32'd3);
        @(posedge spi_sck); #1;
        tx_valid[1] = 1'b0;
        settle(FL + 6);

        // Reset in the middle of a word.
        send_word(0, 16'h0F0F, 1'b0);
        repeat (7) @(negedge spi_sck);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_line", 0, 32'(fo[0]), 32'd1);
        chk("midrst_act",  0, 32'(fa[0]), 32'd0);
        @(posedge spi_sck); #1;
        rst_n = 1'b1;
        settle(1);
        send_word(0, 16'h1234, 1'b0);
        capture(0, DW, w, syncs, act);
        chk("post_rst_bits", 0, w, 32'h0000_1234);
        chk("post_rst_sync", 0, 32'(syncs), 32'd1);
        settle(FL + 3);

        // Randomized traffic on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 40; k++) begin
                settle(int'($urandom_range(0, 3)));
                send_word(i, DW'($urandom), bit'($urandom_range(0, 1)));
            end
            tx_valid[i] = 1'b0;
            settle(FL + 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
